// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the sequenced ALU control block:
//   - alu_code_e : 3-bit ALU control codes driven on alu_ctr
//   - FN_*       : function-field encodings (meaningful when aluop == 0)
//   - OP_*       : ALU-op class encodings from main control
//   - state_e    : sequencer state enumeration
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_ADD = 3'b001,
        ALU_SUB = 3'b010,
        ALU_XOR = 3'b011,
        ALU_NOR = 3'b100,
        ALU_OR  = 3'b101,
        ALU_SLT = 3'b110
    } alu_code_e;

    // Function-field encodings (aluop == OP_RTYPE)
    localparam logic [2:0] FN_AND = 3'b000;
    localparam logic [2:0] FN_ADD = 3'b001;
    localparam logic [2:0] FN_SUB = 3'b010;
    localparam logic [2:0] FN_XOR = 3'b011;
    localparam logic [2:0] FN_NOR = 3'b100;
    localparam logic [2:0] FN_OR  = 3'b101;
    localparam logic [2:0] FN_MUL = 3'b110;

    // ALU-op class encodings
    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_NOR   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_SLT   = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// -----------------------------------------------------------------------------
// alu_ctrl_decode
// Purely combinational decode of an (aluop, funct) request into an ALU code.
// Ports:
//   aluop      [OPW-1:0] in  : ALU-op class from main control
//   funct      [FW-1:0]  in  : function field, consulted only when aluop == 0
//   code       [2:0]     out : decoded ALU control code (ALU_AND when unused)
//   is_mul               out : request is the multicycle multiply
//   is_illegal           out : request cannot be decoded
// -----------------------------------------------------------------------------
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OPW = 3,
    parameter int FW  = 3
) (
    input  logic [OPW-1:0] aluop,
    input  logic [FW-1:0]  funct,
    output logic [2:0]     code,
    output logic           is_mul,
    output logic           is_illegal
);

    logic op_hi_nz;
    logic fn_hi_nz;
    logic rtype;

    // Shifting rather than slicing keeps this valid when the width is exactly 3.
    assign op_hi_nz = |(aluop >> 3);
    assign fn_hi_nz = |(funct >> 3);
    assign rtype    = (aluop == '0);

    // NOTE: every output gets a default before the case so no latch can be
    // inferred on paths that do not assign it.
    always_comb begin
        code       = ALU_AND;
        is_mul     = 1'b0;
        is_illegal = 1'b0;
        if (op_hi_nz) begin
            is_illegal = 1'b1;
        end else if (rtype) begin
            if (fn_hi_nz) begin
                is_illegal = 1'b1;
            end else begin
                case (funct[2:0])
                    FN_AND:  code = ALU_AND;
                    FN_ADD:  code = ALU_ADD;
                    FN_SUB:  code = ALU_SUB;
                    FN_XOR:  code = ALU_XOR;
                    FN_NOR:  code = ALU_NOR;
                    FN_OR:   code = ALU_OR;
                    FN_MUL:  is_mul = 1'b1;
                    default: is_illegal = 1'b1;
                endcase
            end
        end else begin
            case (aluop[2:0])
                OP_ADD:  code = ALU_ADD;
                OP_AND:  code = ALU_AND;
                OP_OR:   code = ALU_OR;
                OP_NOR:  code = ALU_NOR;
                OP_SUB:  code = ALU_SUB;
                OP_SLT:  code = ALU_SLT;
                default: is_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/alu_seq_control.sv
// -----------------------------------------------------------------------------
// alu_seq_control
// Sequenced ALU control: decodes a request, then issues either a one-cycle
// ALU operation, a MUL_STEPS-cycle add/shift multiply, or a one-cycle error.
// Ports:
//   clk, reset          in  : clock; synchronous active-high reset
//   valid               in  : request present
//   aluop [OPW-1:0]     in  : ALU-op class
//   funct [FW-1:0]      in  : function field (aluop == 0 only)
//   flush               in  : abort current operation / block acceptance
//   ready               out : block idle, can accept (combinational from state)
//   alu_ctr [2:0]       out : ALU control code
//   alu_ctr_valid       out : alu_ctr meaningful this cycle
//   acc_shift           out : multiply accumulator/multiplier shift strobe
//   step_cnt [CW-1:0]   out : current multiply iteration
//   done                out : one-cycle completion pulse
//   illegal             out : one-cycle pulse on an undecodable request
// All outputs except ready are registered alongside the state, so the
// *_d values below describe what the block shows in the coming cycle.
// -----------------------------------------------------------------------------
module alu_seq_control
    import alu_ctrl_pkg::*;
#(
    parameter int OPW       = 3,
    parameter int FW        = 3,
    parameter int MUL_STEPS = 32,
    localparam int CW       = $clog2(MUL_STEPS)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           valid,
    input  logic [OPW-1:0] aluop,
    input  logic [FW-1:0]  funct,
    input  logic           flush,
    output logic           ready,
    output logic [2:0]     alu_ctr,
    output logic           alu_ctr_valid,
    output logic           acc_shift,
    output logic [CW-1:0]  step_cnt,
    output logic           done,
    output logic           illegal
);

    localparam logic [CW-1:0] LAST_STEP = CW'(MUL_STEPS - 1);

    state_e        state_q, state_d;
    logic [2:0]    alu_ctr_q, alu_ctr_d;
    logic          alu_ctr_valid_q, alu_ctr_valid_d;
    logic          acc_shift_q, acc_shift_d;
    logic [CW-1:0] step_cnt_q, step_cnt_d;
    logic          done_q, done_d;
    logic          illegal_q, illegal_d;

    logic          accept;
    logic [2:0]    dec_code;
    logic          dec_mul;
    logic          dec_illegal;
    logic [CW-1:0] step_nxt;

    alu_ctrl_decode #(
        .OPW (OPW),
        .FW  (FW)
    ) u_decode (
        .aluop      (aluop),
        .funct      (funct),
        .code       (dec_code),
        .is_mul     (dec_mul),
        .is_illegal (dec_illegal)
    );

    assign ready    = (state_q == ST_IDLE);
    assign accept   = valid & ready & ~flush;
    assign step_nxt = step_cnt_q + CW'(1);

    always_comb begin
        // Defaults are the idle output values; each branch only raises what
        // the coming state shows.
        state_d         = state_q;
        alu_ctr_d       = ALU_AND;
        alu_ctr_valid_d = 1'b0;
        acc_shift_d     = 1'b0;
        step_cnt_d      = '0;
        done_d          = 1'b0;
        illegal_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (dec_illegal) begin
                        state_d   = ST_ERR;
                        illegal_d = 1'b1;
                        done_d    = 1'b1;
                    end else if (dec_mul) begin
                        state_d         = ST_MUL;
                        alu_ctr_d       = ALU_ADD;
                        alu_ctr_valid_d = 1'b1;
                        acc_shift_d     = 1'b1;
                        done_d          = (LAST_STEP == '0);
                    end else begin
                        state_d         = ST_EXEC;
                        alu_ctr_d       = dec_code;
                        alu_ctr_valid_d = 1'b1;
                        done_d          = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                // The last step's done is already on the outputs this cycle;
                // flush only suppresses the steps that would follow.
                if (flush || step_cnt_q == LAST_STEP) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d         = ST_MUL;
                    alu_ctr_d       = ALU_ADD;
                    alu_ctr_valid_d = 1'b1;
                    acc_shift_d     = 1'b1;
                    step_cnt_d      = step_nxt;
                    done_d          = (step_nxt == LAST_STEP);
                end
            end
            // EXEC and ERR always last one cycle, flushed or not.
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            alu_ctr_q       <= ALU_AND;
            alu_ctr_valid_q <= 1'b0;
            acc_shift_q     <= 1'b0;
            step_cnt_q      <= '0;
            done_q          <= 1'b0;
            illegal_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            alu_ctr_q       <= alu_ctr_d;
            alu_ctr_valid_q <= alu_ctr_valid_d;
            acc_shift_q     <= acc_shift_d;
            step_cnt_q      <= step_cnt_d;
            done_q          <= done_d;
            illegal_q       <= illegal_d;
        end
    end

    assign alu_ctr       = alu_ctr_q;
    assign alu_ctr_valid = alu_ctr_valid_q;
    assign acc_shift     = acc_shift_q;
    assign step_cnt      = step_cnt_q;
    assign done          = done_q;
    assign illegal       = illegal_q;

endmodule

// File: tb/tb_alu_seq_control.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_control
// Directed bench for alu_seq_control (OPW=4, FW=3, MUL_STEPS=4). Each request
// pushes the per-cycle output frames it should produce onto a scoreboard
// queue; every cycle pops one frame (or expects the idle frame when empty)
// and compares it with the DUT outputs sampled 1 time unit after the edge.
// Frame bits: {ready, alu_ctr[2:0], alu_ctr_valid, acc_shift, step_cnt[1:0],
//              done, illegal}
// -----------------------------------------------------------------------------
module tb_alu_seq_control;

    localparam int OPW   = 4;
    localparam int FW    = 3;
    localparam int STEPS = 4;

    typedef logic [9:0] frame_t;
    localparam frame_t IDLE_FRAME = 10'b1_000_0_0_00_0_0;

    logic           clk = 1'b0;
    logic           reset;
    logic           valid;
    logic [OPW-1:0] aluop;
    logic [FW-1:0]  funct;
    logic           flush;
    logic           ready;
    logic [2:0]     alu_ctr;
    logic           alu_ctr_valid;
    logic           acc_shift;
    logic [1:0]     step_cnt;
    logic           done;
    logic           illegal;

    int     n_compared   = 0;
    int     n_mismatched = 0;
    int     cyc          = 0;
    string  cur_tag      = "init";
    frame_t exp_q[$];

    alu_seq_control #(
        .OPW       (OPW),
        .FW        (FW),
        .MUL_STEPS (STEPS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .valid         (valid),
        .aluop         (aluop),
        .funct         (funct),
        .flush         (flush),
        .ready         (ready),
        .alu_ctr       (alu_ctr),
        .alu_ctr_valid (alu_ctr_valid),
        .acc_shift     (acc_shift),
        .step_cnt      (step_cnt),
        .done          (done),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    // Reference decode table.
    function automatic void ref_decode(input logic [OPW-1:0] op, input logic [FW-1:0] fn,
                                       output logic [2:0] code, output logic mul,
                                       output logic ill);
        code = 3'b000;
        mul  = 1'b0;
        ill  = 1'b0;
        if (op[3]) begin
            ill = 1'b1;
        end else if (op == 4'b0000) begin
            case (fn)
                3'b000: code = 3'b000;
                3'b001: code = 3'b001;
                3'b010: code = 3'b010;
                3'b011: code = 3'b011;
                3'b100: code = 3'b100;
                3'b101: code = 3'b101;
                3'b110: mul  = 1'b1;
                default: ill = 1'b1;
            endcase
        end else begin
            case (op[2:0])
                3'b001: code = 3'b001;
                3'b010: code = 3'b000;
                3'b011: code = 3'b101;
                3'b100: code = 3'b100;
                3'b101: code = 3'b010;
                3'b110: code = 3'b110;
                default: ill = 1'b1;
            endcase
        end
    endfunction

    // Advance one clock and compare the outputs against the next frame.
    task automatic step_cycle();
        frame_t obs;
        frame_t exp;
        @(posedge clk);
        #1;
        cyc++;
        obs = {ready, alu_ctr, alu_ctr_valid, acc_shift, step_cnt, done, illegal};
        exp = (exp_q.size() == 0) ? IDLE_FRAME : exp_q.pop_front();
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s (cycle %0d): observed=%b expected=%b", cur_tag, cyc, obs, exp);
        end
    endtask

    // Drive one request for a single cycle; expected frames are pushed from
    // the reference decode. mul_frames limits how many multiply steps are
    // expected (for aborted multiplies).
    task automatic issue(input logic [OPW-1:0] op, input logic [FW-1:0] fn,
                         input string tag, input int mul_frames);
        logic [2:0] code;
        logic       mul;
        logic       ill;
        ref_decode(op, fn, code, mul, ill);
        cur_tag = tag;
        if (ill) begin
            exp_q.push_back({1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1});
        end else if (mul) begin
            for (int i = 0; i < mul_frames; i++)
                exp_q.push_back({1'b0, 3'b001, 1'b1, 1'b1, 2'(i), (i == STEPS - 1), 1'b0});
        end else begin
            exp_q.push_back({1'b0, code, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0});
        end
        valid = 1'b1;
        aluop = op;
        funct = fn;
        step_cycle();
        valid = 1'b0;
    endtask

    initial begin
        logic [OPW-1:0] legal_op[12] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
                                         4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        logic [FW-1:0]  legal_fn[12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
                                         3'd7, 3'd6, 3'd0, 3'd5, 3'd3, 3'd2};
        reset = 1'b1;
        valid = 1'b0;
        flush = 1'b0;
        aluop = '0;
        funct = '0;

        // Reset held two cycles, with a request present that must be ignored.
        cur_tag = "reset";
        valid   = 1'b1;
        step_cycle();
        step_cycle();
        valid = 1'b0;
        reset = 1'b0;
        cur_tag = "post_reset";
        step_cycle();

        // All twelve legal single-cycle requests.
        for (int i = 0; i < 12; i++) begin
            issue(legal_op[i], legal_fn[i], $sformatf("legal_%0d", i), 0);
            cur_tag = "legal_return_idle";
            step_cycle();
        end

        // A request presented during EXEC is not accepted.
        issue(4'd5, 3'd0, "exec_sub", 0);
        cur_tag = "busy_ignored";
        valid = 1'b1;
        aluop = 4'd1;
        step_cycle();
        valid = 1'b0;
        step_cycle();

        // Full multiply.
        issue(4'd0, 3'd6, "mul_full", STEPS);
        for (int i = 1; i < STEPS; i++) step_cycle();
        cur_tag = "mul_return_idle";
        step_cycle();

        // Illegal requests: aluop 0111, aluop 1001, funct 111.
        issue(4'b0111, 3'd0, "illegal_op7", 0);
        step_cycle();
        issue(4'b1001, 3'd1, "illegal_op_hi", 0);
        step_cycle();
        issue(4'b0000, 3'd7, "illegal_fn7", 0);
        step_cycle();

        // Flush while step_cnt == 2: back to idle, no done.
        issue(4'd0, 3'd6, "mul_flush", 3);
        step_cycle();
        step_cycle();
        flush   = 1'b1;
        cur_tag = "mul_flushed";
        step_cycle();
        flush = 1'b0;
        step_cycle();

        // valid together with flush in IDLE: nothing accepted.
        cur_tag = "idle_flush";
        valid = 1'b1;
        flush = 1'b1;
        aluop = 4'd1;
        step_cycle();
        valid = 1'b0;
        flush = 1'b0;
        step_cycle();

        // Reset while step_cnt == 1, then a normal ADD.
        issue(4'd0, 3'd6, "mul_reset", 2);
        step_cycle();
        reset   = 1'b1;
        cur_tag = "mul_reset_abort";
        step_cycle();
        reset = 1'b0;
        step_cycle();
        issue(4'd1, 3'd0, "add_after_reset", 0);
        cur_tag = "final_idle";
        step_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/alu_seq_control.md
ALU_SEQ_CONTROL -- requirements
Module: alu_seq_control

Interface
REQ-001 Parameter OPW, default 3, ALU-op input width (>=3).
REQ-002 Parameter FW, default 3, function-field input width (>=3).
REQ-003 Parameter MUL_STEPS, default 32, add/shift iterations per multiply (2..256).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 valid  input  1  request present.
REQ-007 aluop  input  OPW  ALU-op class from main control.
REQ-008 funct  input  FW  function field, used only when aluop==0.
REQ-009 flush  input  1  abort the current operation.
REQ-010 ready  output  1  block can accept a request.
REQ-011 alu_ctr  output  3  ALU control code.
REQ-012 alu_ctr_valid  output  1  alu_ctr is meaningful this cycle.
REQ-013 acc_shift  output  1  multiply accumulator/multiplier shift strobe.
REQ-014 step_cnt  output  clog2(MUL_STEPS)  current multiply iteration.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 illegal  output  1  one-cycle pulse on an undecodable request.

Function
REQ-017 Decode, aluop==0: funct 000 AND->000, 001 ADD->001, 010 SUB->010, 011 XOR->011, 100 NOR->100, 101 OR->101, 110 MUL (multicycle), 111 illegal.
REQ-018 Decode, aluop!=0: 001 ADD->001, 010 AND->000, 011 OR->101, 100 NOR->100, 101 SUB->010, 110 SLT->110, 111 illegal.
REQ-019 Any nonzero bit above bit 2 of aluop, or of funct when aluop==0, makes the request illegal.
REQ-020 States: IDLE, EXEC, MUL, ERR; ready = (state==IDLE), combinational from the state register.
REQ-021 Accept = valid & ready & ~flush; aluop/funct are sampled only on accept; inputs are ignored in all other cycles.
REQ-022 IDLE->EXEC on accepting a single-cycle op; EXEC lasts exactly one cycle: alu_ctr = decoded code, alu_ctr_valid=1, done=1; then ->IDLE.
REQ-023 IDLE->MUL on accepting MUL; MUL lasts MUL_STEPS cycles: alu_ctr=001, alu_ctr_valid=1, acc_shift=1, step_cnt counts 0..MUL_STEPS-1.
REQ-024 done=1 only in the cycle where step_cnt==MUL_STEPS-1; then ->IDLE, step_cnt->0.
REQ-025 IDLE->ERR on accepting an illegal request; ERR lasts one cycle: illegal=1, done=1, alu_ctr_valid=0; then ->IDLE.
REQ-026 Latency: single-cycle op output is valid 1 cycle after accept; MUL 1..MUL_STEPS cycles after accept; next accept is possible in the cycle after done (minimum 2-cycle spacing).
REQ-027 flush in EXEC, MUL or ERR: the next state is IDLE, with no done or illegal pulse, and step_cnt->0; the outputs of the current cycle are still driven as specified for that state.
REQ-028 flush together with valid in IDLE: flush wins and nothing is accepted.
REQ-029 Outside EXEC/MUL: alu_ctr=000, alu_ctr_valid=0, acc_shift=0; outside MUL: step_cnt=0.
REQ-030 All outputs other than ready are registered.

Reset
REQ-031 reset forces state=IDLE, alu_ctr=000, alu_ctr_valid=0, acc_shift=0, step_cnt=0, done=0, illegal=0; ready=1 in the first cycle after reset.
REQ-032 reset overrides valid and flush, and aborts any operation mid-flight (including MUL) with no done pulse.

Structure
REQ-033 The shared package alu_ctrl_pkg holds the 3-bit ALU codes (AND, ADD, SUB, XOR, NOR, OR, SLT), the funct/aluop encodings, and the state enumeration.
REQ-034 The combinational decoder (REQ-017..019) is a separate sub-module, alu_ctrl_decode, with outputs code, is_mul and is_illegal; the FSM and counter live in alu_seq_control.

Verification
REQ-035 reset high 2 cycles, then low -> ready=1, all other outputs 0.
REQ-036 All 12 legal aluop/funct pairs of REQ-017/018, each with a single valid pulse -> one cycle later alu_ctr matches the table, alu_ctr_valid=1, done=1.
REQ-037 MUL_STEPS=4, aluop=000, funct=110 -> 4 cycles of alu_ctr=001 and acc_shift=1 with step_cnt 0,1,2,3; done only at step 3; ready=0 throughout.
REQ-038 aluop=111; then OPW=4 with aluop=1001 -> each gives illegal=1 and done=1 for one cycle, with alu_ctr_valid=0.
REQ-039 flush at step_cnt=2 of MUL -> IDLE next cycle, with no done pulse; valid+flush in IDLE -> ready stays 1 and nothing is issued.
REQ-040 reset at step_cnt=1 of MUL -> the next cycle shows IDLE and all outputs at their reset values; a new ADD request then completes normally.
